// File: rtl/instr_mem_sync_if.sv
// Fetch and program-load signal bundle for instr_mem_sync.
// The master side is the IF stage/loader; the slave side is the memory.
interface instr_mem_sync_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [31:0]       pc_in;
    logic              fetch_en;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              addr_fault;
    logic              ld_start;
    logic [ADDR_W-1:0] ld_base;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              load_busy;

    modport master (
        output pc_in, fetch_en, ld_start, ld_base, ld_valid, ld_data, ld_last,
        input  instr, instr_valid, addr_fault, ld_ready, load_busy
    );

    modport slave (
        input  pc_in, fetch_en, ld_start, ld_base, ld_valid, ld_data, ld_last,
        output instr, instr_valid, addr_fault, ld_ready, load_busy
    );
endinterface

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory with stall hold and fault flagging.
// Define IMEM_LOAD_EN to compile in the run-time load port (RUN/LOAD/DRAIN FSM).
module instr_mem_sync #(
    parameter int              ADDR_W   = 8,
    parameter int              DATA_W   = 32,
    parameter int              PC_SHIFT = 0,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic             clk,
    input  logic             reset,
    instr_mem_sync_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    // Contents survive reset; only time-zero initialisation sets them.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

    logic [31:0]       idx_full;
    logic [ADDR_W-1:0] idx;
    logic              out_of_range;
    logic              misaligned;
    logic              fault;
    logic              block_fetch;

    always_comb begin
        idx_full     = bus.pc_in >> PC_SHIFT;
        idx          = idx_full[ADDR_W-1:0];
        out_of_range = (idx_full >> ADDR_W) != '0;
        misaligned   = (bus.pc_in & ((32'd1 << PC_SHIFT) - 32'd1)) != '0;
        fault        = out_of_range | misaligned;
    end

`ifdef IMEM_LOAD_EN
    typedef enum logic [1:0] {RUN, LOAD, DRAIN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;
    logic              wr_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        wr_en         = 1'b0;
        bus.ld_ready  = 1'b0;
        bus.load_busy = 1'b0;
        case (state)
            RUN: begin
                if (bus.ld_start) begin
                    state_next = LOAD;
                    cnt_next   = bus.ld_base;
                end
            end
            LOAD: begin
                bus.ld_ready  = 1'b1;
                bus.load_busy = 1'b1;
                if (bus.ld_valid) begin
                    wr_en    = 1'b1;
                    cnt_next = cnt + ADDR_W'(1);
                    if (bus.ld_last) state_next = DRAIN;
                end
            end
            DRAIN: begin
                bus.load_busy = 1'b1;
                state_next    = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // A load request beats a same-cycle fetch and blanks the output.
    assign block_fetch = (state != RUN) || bus.ld_start;

    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem[cnt] <= bus.ld_data;
    end
`else
    logic unused_ld;

    assign unused_ld     = ^{bus.ld_start, bus.ld_base, bus.ld_valid, bus.ld_data, bus.ld_last};
    assign block_fetch   = 1'b0;
    assign bus.ld_ready  = 1'b0;
    assign bus.load_busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.instr       <= NOP_WORD;
            bus.instr_valid <= 1'b0;
            bus.addr_fault  <= 1'b0;
        end else if (block_fetch) begin
            bus.instr       <= NOP_WORD;
            bus.instr_valid <= 1'b0;
            bus.addr_fault  <= 1'b0;
        end else if (bus.fetch_en) begin
            bus.instr       <= fault ? NOP_WORD : mem[idx];
            bus.instr_valid <= 1'b1;
            bus.addr_fault  <= fault;
        end
    end
endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench: a word-PC and a byte-PC instance checked every cycle
// against a behavioural model, plus directed literal expectations.
module tb_instr_mem_sync;
    localparam logic [31:0] NOP_W = 32'h0000_0000;
    localparam logic [31:0] NOP_B = 32'h0000_0013;
`ifdef IMEM_LOAD_EN
    localparam logic [31:0] EXP5 = 32'h0441_0000;
`else
    localparam logic [31:0] EXP5 = NOP_W;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic cmp_on;

    instr_mem_sync_if #(.ADDR_W(8), .DATA_W(32)) bw ();
    instr_mem_sync_if #(.ADDR_W(8), .DATA_W(32)) bb ();

    instr_mem_sync #(.ADDR_W(8), .DATA_W(32), .PC_SHIFT(0), .NOP_WORD(NOP_W)) dut_w (
        .clk(clk), .reset(reset), .bus(bw)
    );
    instr_mem_sync #(.ADDR_W(8), .DATA_W(32), .PC_SHIFT(2), .NOP_WORD(NOP_B)) dut_b (
        .clk(clk), .reset(reset), .bus(bb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: [0] = word-PC instance, [1] = byte-PC instance
    logic [31:0] m_mem [2][256];
    logic [31:0] m_instr [2];
    logic        m_valid [2];
    logic        m_fault [2];
    int          m_mode [2];   // 0 fetching, 1 accepting load words, 2 drain cycle
    int          m_ptr [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_cycle(input int d, input logic [31:0] pc, input logic fe, input logic ls,
                               input logic [7:0] lb, input logic lv, input logic [31:0] ld,
                               input logic ll);
        int unsigned stride;
        int unsigned widx;
        logic [31:0] nop;
        logic        bad;
        stride = (d == 0) ? 1 : 4;
        nop    = (d == 0) ? NOP_W : NOP_B;
        widx   = pc / stride;
        bad    = ((pc % stride) != 0) || (widx >= 256);
        if (reset) begin
            m_instr[d] = nop; m_valid[d] = 1'b0; m_fault[d] = 1'b0;
            m_mode[d]  = 0;   m_ptr[d]   = 0;
        end else begin
`ifdef IMEM_LOAD_EN
            if (m_mode[d] == 2) begin
                m_mode[d] = 0;
            end else if (m_mode[d] == 1) begin
                if (lv) begin
                    m_mem[d][m_ptr[d]] = ld;
                    m_ptr[d] = (m_ptr[d] + 1) % 256;
                    if (ll) m_mode[d] = 2;
                end
            end else if (ls) begin
                m_mode[d] = 1; m_ptr[d] = int'(lb);
                m_instr[d] = nop; m_valid[d] = 1'b0; m_fault[d] = 1'b0;
            end else if (fe) begin
                m_instr[d] = bad ? nop : m_mem[d][widx[7:0]];
                m_valid[d] = 1'b1; m_fault[d] = bad;
            end
`else
            if (ls || lv || ll || (lb != lb) || (ld != ld)) m_ptr[d] = 0;
            if (fe) begin
                m_instr[d] = bad ? nop : m_mem[d][widx[7:0]];
                m_valid[d] = 1'b1; m_fault[d] = bad;
            end
`endif
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) m_mem[d][i] = (d == 0) ? NOP_W : NOP_B;
            m_mode[d] = 0; m_ptr[d] = 0;
        end
    end

    always @(posedge clk) begin
        model_cycle(0, bw.pc_in, bw.fetch_en, bw.ld_start, bw.ld_base, bw.ld_valid, bw.ld_data, bw.ld_last);
        model_cycle(1, bb.pc_in, bb.fetch_en, bb.ld_start, bb.ld_base, bb.ld_valid, bb.ld_data, bb.ld_last);
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("w.instr",       bw.instr,              m_instr[0]);
            check("w.instr_valid", 32'(bw.instr_valid),   32'(m_valid[0]));
            check("w.addr_fault",  32'(bw.addr_fault),    32'(m_fault[0]));
            check("w.ld_ready",    32'(bw.ld_ready),      32'(m_mode[0] == 1));
            check("w.load_busy",   32'(bw.load_busy),     32'(m_mode[0] != 0));
            check("b.instr",       bb.instr,              m_instr[1]);
            check("b.instr_valid", 32'(bb.instr_valid),   32'(m_valid[1]));
            check("b.addr_fault",  32'(bb.addr_fault),    32'(m_fault[1]));
            check("b.ld_ready",    32'(bb.ld_ready),      32'(m_mode[1] == 1));
            check("b.load_busy",   32'(bb.load_busy),     32'(m_mode[1] != 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ld_begin(input logic [7:0] base);
        bw.ld_start = 1'b1; bw.ld_base = base;
        tick();
        bw.ld_start = 1'b0;
    endtask

    task automatic ld_word(input logic [31:0] data, input logic last);
        bw.ld_valid = 1'b1; bw.ld_data = data; bw.ld_last = last;
        tick();
        bw.ld_valid = 1'b0; bw.ld_last = 1'b0;
    endtask

    task automatic fetch_w(input logic [31:0] pc, input logic [31:0] exp, input string name);
        bw.fetch_en = 1'b1; bw.pc_in = pc;
        tick();
        check(name, bw.instr, exp);
        check({name, ".valid"}, 32'(bw.instr_valid), 32'd1);
    endtask

    logic [31:0] pcw [6] = '{32'd255, 32'd256, 32'd300, 32'd0, 32'hFFFF_FFFF, 32'd5};
    logic        fw  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] pcb [6] = '{32'd6, 32'd8, 32'd1020, 32'd1024, 32'd1023, 32'h8000_0000};
    logic        fb  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        checks = 0; errors = 0; cmp_on = 1'b0;
        reset = 1'b1;
        bw.pc_in = '0; bw.fetch_en = 1'b0; bw.ld_start = 1'b0; bw.ld_base = '0;
        bw.ld_valid = 1'b0; bw.ld_data = '0; bw.ld_last = 1'b0;
        bb.pc_in = '0; bb.fetch_en = 1'b0; bb.ld_start = 1'b0; bb.ld_base = '0;
        bb.ld_valid = 1'b0; bb.ld_data = '0; bb.ld_last = 1'b0;

        tick();
        cmp_on = 1'b1;
        tick();
        check("rst w.instr", bw.instr, NOP_W);
        check("rst w.valid", 32'(bw.instr_valid), 32'd0);
        check("rst b.instr", bb.instr, NOP_B);
        check("rst w.busy",  32'(bw.load_busy), 32'd0);
        check("rst w.ready", 32'(bw.ld_ready), 32'd0);
        reset = 1'b0;

`ifdef IMEM_LOAD_EN
        ld_begin(8'd5);
        ld_word(32'h0441_0000, 1'b1);
        tick();
        check("load5 busy clear", 32'(bw.load_busy), 32'd0);
`endif
        fetch_w(32'd5, EXP5, "fetch pc5");

        // Stall: pc changes but outputs must hold
        bw.fetch_en = 1'b0; bw.pc_in = 32'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall hold", bw.instr, EXP5);
        end

        // Range and alignment boundaries on both instances simultaneously
        bw.fetch_en = 1'b1; bb.fetch_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bw.pc_in = pcw[i]; bb.pc_in = pcb[i];
            tick();
            check("w fault", 32'(bw.addr_fault), 32'(fw[i]));
            check("b fault", 32'(bb.addr_fault), 32'(fb[i]));
            check("b instr", bb.instr, NOP_B);
        end
        check("w legal after fault", bw.instr, EXP5);
        bw.fetch_en = 1'b0; bb.fetch_en = 1'b0;

`ifdef IMEM_LOAD_EN
        begin
            int busy_cnt;
            busy_cnt = 0;
            bw.fetch_en = 1'b1; bw.pc_in = 32'd7;   // same-cycle fetch must lose to ld_start
            ld_begin(8'd254);
            check("ld_start wins valid", 32'(bw.instr_valid), 32'd0);
            bw.fetch_en = 1'b0;
            if (bw.load_busy) busy_cnt++;
            ld_word(32'hA0A0_0001, 1'b0);
            if (bw.load_busy) busy_cnt++;
            ld_word(32'hA0A0_0002, 1'b0);
            if (bw.load_busy) busy_cnt++;
            ld_word(32'hA0A0_0003, 1'b1);
            if (bw.load_busy) busy_cnt++;
            check("drain ready low", 32'(bw.ld_ready), 32'd0);
            bw.fetch_en = 1'b1; bw.pc_in = 32'd0;
            tick();
            if (bw.load_busy) busy_cnt++;
            check("busy cycles", 32'(busy_cnt), 32'd4);
            fetch_w(32'd0,   32'hA0A0_0003, "wrap mem0");
            fetch_w(32'd254, 32'hA0A0_0001, "wrap mem254");
            fetch_w(32'd255, 32'hA0A0_0002, "wrap mem255");
            bw.fetch_en = 1'b0;
        end

        // Reset in the middle of a 4-word burst over pre-programmed words
        ld_begin(8'd12);
        ld_word(32'hBEEF_0012, 1'b0);
        ld_word(32'hBEEF_0013, 1'b1);
        tick();
        ld_begin(8'd10);
        ld_word(32'hD000_0010, 1'b0);
        ld_word(32'hD000_0011, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midload busy", 32'(bw.load_busy), 32'd0);
        check("midload ready", 32'(bw.ld_ready), 32'd0);
        fetch_w(32'd10, 32'hD000_0010, "midload mem10");
        fetch_w(32'd11, 32'hD000_0011, "midload mem11");
        fetch_w(32'd12, 32'hBEEF_0012, "midload mem12");
        fetch_w(32'd13, 32'hBEEF_0013, "midload mem13");
        bw.fetch_en = 1'b0;
`else
        bw.ld_start = 1'b1; bw.ld_base = 8'd254; bw.ld_valid = 1'b1;
        bw.ld_data = 32'hDEAD_BEEF; bw.ld_last = 1'b1;
        tick();
        check("off ready", 32'(bw.ld_ready), 32'd0);
        check("off busy",  32'(bw.load_busy), 32'd0);
        bw.ld_start = 1'b0; bw.ld_valid = 1'b0; bw.ld_last = 1'b0;
        tick();
        check("off busy2", 32'(bw.load_busy), 32'd0);
        fetch_w(32'd254, NOP_W, "off mem254");
        fetch_w(32'd0,   NOP_W, "off mem0");
        bw.fetch_en = 1'b0;
`endif
        tick();
        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_mem_sync.md
# instr_mem_sync

Parametrised, synchronous-read instruction memory for the IF stage of the pipeline. It replaces the fixed 256-word combinational code store with a registered fetch path that holds its output under pipeline stall. It supports word- or byte-addressed PCs and flags out-of-range or misaligned fetches. An optional load port writes program words at run time, so the bench and the boot path can reprogram code without recompiling.

## Interface
- `ADDR_W`, 8: word-index width; depth = 2^ADDR_W words.
- `DATA_W`, 32: instruction width.
- `PC_SHIFT`, 0: word index = `pc_in >> PC_SHIFT`; 0 = word PC, 2 = byte PC.
- `NOP_WORD`, 32'h0000_0000: word driven on fault, reset and load.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc_in`  in  32  fetch address from PC register.
- `fetch_en`  in  1  1 = IF advancing, sample `pc_in`; 0 = stall, hold outputs.
- `instr`  out  DATA_W  registered instruction.
- `instr_valid`  out  1  `instr` corresponds to a real fetch.
- `addr_fault`  out  1  last sampled fetch was out of range or misaligned.
- `ld_start`  in  1  pulse: begin a load burst.
- `ld_base`  in  ADDR_W  first word index of the burst, sampled with `ld_start`.
- `ld_valid`  in  1  `ld_data` present.
- `ld_data`  in  DATA_W  word to write.
- `ld_last`  in  1  qualifies the final word of the burst.
- `ld_ready`  out  1  memory accepts a load word this cycle.
- `load_busy`  out  1  block is in LOAD or DRAIN.

## Operation
- FSM states: RUN, LOAD, DRAIN. The state is RUN after reset.
- **RUN, `fetch_en`=1:** `idx = pc_in >> PC_SHIFT`.
  - Fault if `idx >= 2^ADDR_W`, or if `pc_in[PC_SHIFT-1:0] != 0` when PC_SHIFT>0.
  - No fault: `instr <= mem[idx]`, `instr_valid <= 1`, `addr_fault <= 0`.
  - Fault: `instr <= NOP_WORD`, `instr_valid <= 1`, `addr_fault <= 1`.
- **RUN, `fetch_en`=0:** `instr`, `instr_valid` and `addr_fault` hold their values.
- **RUN, `ld_start`=1:** go to LOAD and set `cnt <= ld_base`.
  - The fetch in the same cycle is discarded: `instr <= NOP_WORD`, `instr_valid <= 0`.
- **LOAD:**
  - `ld_ready`=1.
  - On `ld_valid`: `mem[cnt] <= ld_data` and `cnt <= cnt+1`. The counter wraps modulo 2^ADDR_W.
  - `ld_valid & ld_last`: write the word, then go to DRAIN.
  - `ld_start` is ignored in this state.
- **DRAIN:** one cycle with `ld_ready`=0, then go to RUN.
- **LOAD and DRAIN outputs:** `instr`=NOP_WORD, `instr_valid`=0, `addr_fault`=0, `fetch_en` ignored, `load_busy`=1.
- Memory contents are not cleared by reset. At time zero every word is initialised to NOP_WORD.

## Timing
- **Reset values:** `instr`=NOP_WORD, `instr_valid`=0, `addr_fault`=0, `ld_ready`=0, `load_busy`=0, `cnt`=0, state RUN.
- **Fetch latency:** 1 cycle. `pc_in` sampled at edge N appears on `instr` after edge N.
- **Load throughput:** 1 word/cycle, with no wait states in LOAD.
- **Load-to-fetch:** the first RUN fetch after DRAIN returns the newly written data, including the `ld_last` word. There is no read-during-write hazard.
- **`fetch_en` and `ld_start` in the same cycle:** `ld_start` wins.
- **Reset during LOAD or DRAIN:** return to RUN immediately. Words already written are kept; the rest of the burst is lost.
- **`ld_valid` while not in LOAD:** ignored; no write.

## Configuration
- Macro: `IMEM_LOAD_EN`.
- **Defined:** load port, FSM and `cnt` are compiled in as described above.
- **Undefined:**
  - The memory is read-only; the state is permanently RUN.
  - `ld_*` inputs are ignored, and `ld_ready` and `load_busy` are tied to 0.
  - Contents come only from time-zero initialisation.
  - The fetch path is unchanged.

## Test plan
- **Reset and basic fetch:**
  - Assert reset 2 cycles: `instr`=0, `instr_valid`=0.
  - Then load mem[5]=32'h0441_0000 and fetch `pc_in`=5 with PC_SHIFT=0: `instr`=32'h0441_0000 one cycle later, `instr_valid`=1.
- **Stall hold:** fetch pc=5, then `fetch_en`=0 for 3 cycles with pc=6: `instr` stays 32'h0441_0000 throughout.
- **Faults:**
  - PC_SHIFT=2, `pc_in`=32'h0000_0006: `instr`=NOP_WORD, `addr_fault`=1.
  - ADDR_W=8, PC_SHIFT=0, `pc_in`=300: `addr_fault`=1.
  - Next legal fetch clears `addr_fault` to 0.
- **Load burst with wrap:**
  - `ld_start` with `ld_base`=254, then write 3 words A, B, C, with `ld_last` on C.
  - Required: mem[254]=A, mem[255]=B, mem[0]=C.
  - `load_busy`=1 for 4 cycles (3 LOAD + 1 DRAIN).
  - Fetch pc=0 right after DRAIN returns C.
- **Reset mid-load:**
  - Reset after 2 of 4 words: state RUN, `load_busy`=0.
  - The 2 written words read back correctly; the other 2 target words still read their prior contents.
- **Macro off:** `ld_start` and `ld_valid` pulsed: `ld_ready`=0, `load_busy`=0, and fetches return the initial contents unchanged.
